// File: rtl/tdm_demux.sv
// Word-to-frame deserializer: one word per cycle in; frame out one cycle after its closing word.
// Only the closing word can stall, when the output frame is still held and not being drained.
module tdm_demux #(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BIT_WIDTH-1:0]       dataIn,
  input  logic                       inValid,
  input  logic                       frameStart,
  output logic                       inReady,
  output logic [BIT_WIDTH*DEPTH-1:0] dataOut,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [SEL_WIDTH-1:0]       laneSel,
  output logic                       frameErr
);
  localparam int FW = BIT_WIDTH * DEPTH;
  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(DEPTH - 1);

  logic [SEL_WIDTH-1:0] r_lane;
  logic [FW-1:0]        r_stage;
  logic [FW-1:0]        r_dout;
  logic                 r_ovld;
  logic                 r_err;

  logic                 w_last;
  logic                 w_acc;
  logic                 w_done;
  logic [SEL_WIDTH-1:0] w_idx;
  logic [FW-1:0]        w_stage_nxt;

  assign w_last  = (r_lane == LAST);
  assign inReady = ~w_last | ~r_ovld | outReady;
  assign w_acc   = inValid & inReady;
  // A frameStart word restarts at lane 0 and can never close a frame.
  assign w_done  = w_acc & ~frameStart & w_last;
  assign w_idx   = frameStart ? '0 : r_lane;

  // Staging with the incoming word merged in, so a closing word reaches dataOut directly.
  always_comb begin
    w_stage_nxt = r_stage;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_acc && (w_idx == SEL_WIDTH'(k))) begin
        w_stage_nxt[k*BIT_WIDTH +: BIT_WIDTH] = dataIn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_stage <= '0;
      r_dout  <= '0;
      r_ovld  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_acc & frameStart & (r_lane != '0);
      if (w_acc) begin
        r_stage <= w_stage_nxt;
        if (frameStart) begin
          r_lane <= SEL_WIDTH'(1);
        end else if (w_last) begin
          r_lane <= '0;
        end else begin
          r_lane <= r_lane + SEL_WIDTH'(1);
        end
      end
      if (w_done) begin
        r_dout <= w_stage_nxt;
        r_ovld <= 1'b1;
      end else if (r_ovld & outReady) begin
        r_ovld <= 1'b0;
      end
    end
  end

  assign dataOut  = r_dout;
  assign outValid = r_ovld;
  assign laneSel  = r_lane;
  assign frameErr = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: 4x4-bit instance against a reference model and frame scoreboard,
// plus a 3x2-bit instance for the non-power-of-two lane wrap.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  a_din;
  logic        a_vld, a_fs, a_rdy, a_ovld, a_ordy, a_err;
  logic [15:0] a_dout;
  logic [1:0]  a_lane;

  logic [1:0]  b_din;
  logic        b_vld, b_fs, b_rdy, b_ovld, b_ordy, b_err;
  logic [5:0]  b_dout;
  logic [1:0]  b_lane;

  tdm_demux #(.BIT_WIDTH(4), .DEPTH(4), .SEL_WIDTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .dataIn(a_din), .inValid(a_vld), .frameStart(a_fs),
    .inReady(a_rdy), .dataOut(a_dout), .outValid(a_ovld), .outReady(a_ordy),
    .laneSel(a_lane), .frameErr(a_err)
  );

  tdm_demux #(.BIT_WIDTH(2), .DEPTH(3), .SEL_WIDTH(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .dataIn(b_din), .inValid(b_vld), .frameStart(b_fs),
    .inReady(b_rdy), .dataOut(b_dout), .outValid(b_ovld), .outReady(b_ordy),
    .laneSel(b_lane), .frameErr(b_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [15:0] qa[$];
  logic [5:0]  qb[$];

  // Reference model of instance A; evaluated mid-low-phase, predicting the next rising edge.
  logic [1:0]  m_lane;
  logic [15:0] m_stage;
  logic        m_ovld, m_err, m_rdy, m_acc, m_done;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      m_lane = '0; m_stage = '0; m_ovld = 1'b0; m_err = 1'b0;
      qa.delete();
    end else begin
      m_rdy = (m_lane != 2'd3) || !m_ovld || a_ordy;
      check("a_lane", a_lane, m_lane);
      check("a_ovld", a_ovld, m_ovld);
      check("a_err", a_err, m_err);
      check("a_rdy", a_rdy, m_rdy);
      if (m_ovld) begin
        check("a_sb_nonempty", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          check("a_frame", a_dout, qa[0]);
          if (a_ordy) void'(qa.pop_front());
        end
      end
      m_acc  = a_vld && m_rdy;
      m_err  = m_acc && a_fs && (m_lane != 2'd0);
      m_done = m_acc && !a_fs && (m_lane == 2'd3);
      if (m_acc) m_stage[(a_fs ? 0 : int'(m_lane))*4 +: 4] = a_din;
      if (m_done) begin
        qa.push_back(m_stage);
        m_ovld = 1'b1;
      end else if (m_ovld && a_ordy) begin
        m_ovld = 1'b0;
      end
      if (m_acc) begin
        if (a_fs) m_lane = 2'd1;
        else if (m_lane == 2'd3) m_lane = 2'd0;
        else m_lane = m_lane + 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      qb.delete();
    end else begin
      check("b_lane_range", b_lane < 2'd3, 1);
      if (b_ovld) begin
        check("b_sb_nonempty", qb.size() > 0, 1);
        if (qb.size() > 0) check("b_frame", b_dout, qb.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] w, input logic fs);
    int n = 0;
    @(negedge clk);
    a_vld = 1'b1; a_din = w; a_fs = fs;
    #2;
    while (!a_rdy && n < 50) begin
      @(negedge clk); #2; n++;
    end
    if (!a_rdy) check("send_timeout", a_rdy, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    a_vld = 1'b0; a_fs = 1'b0;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [5:0] bf;
    rst_n = 1'b1;
    a_din = '0; a_vld = 1'b0; a_fs = 1'b0; a_ordy = 1'b1;
    b_din = '0; b_vld = 1'b0; b_fs = 1'b0; b_ordy = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("rst_lane", a_lane, 0);
    check("rst_ovld", a_ovld, 0);
    check("rst_dout", a_dout, 0);
    check("rst_err", a_err, 0);
    check("rst_rdy", a_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single frame, lane 0 in the low nibble
    send(4'h3, 1'b1); send(4'h2, 1'b0); send(4'h1, 1'b0); send(4'h0, 1'b0);
    idle();
    check("t1_ovld", a_ovld, 1);
    check("t1_dout", a_dout, 16'h0123);
    @(negedge clk); #2;
    check("t1_ovld_drop", a_ovld, 0);

    // 2: back-to-back stream of three frames
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_vld = 1'b1; a_din = 4'(i + 5); a_fs = (i % 4 == 0);
      #2;
      check("t2_rdy", a_rdy, 1);
      check("t2_lane", a_lane, i % 4);
    end
    idle();

    // 3: output held, closing word of frame 2 stalls, then zero-bubble reload
    @(negedge clk);
    a_ordy = 1'b0;
    send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0);
    @(negedge clk);
    a_vld = 1'b1; a_din = 4'h8; a_fs = 1'b0;
    #2;
    check("t3_rdy_blocked", a_rdy, 0);
    check("t3_hold", a_dout, 16'h4321);
    @(negedge clk); #2;
    check("t3_hold2", a_dout, 16'h4321);
    check("t3_lane", a_lane, 3);
    @(negedge clk);
    a_ordy = 1'b1;
    #2;
    check("t3_rdy_open", a_rdy, 1);
    idle();
    check("t3_bubble_vld", a_ovld, 1);
    check("t3_frame2", a_dout, 16'h8765);

    // 4: frameStart mid-frame discards the partial frame
    send(4'h5, 1'b1); send(4'h6, 1'b0); send(4'h9, 1'b1);
    send(4'h7, 1'b0);
    check("t4_err", a_err, 1);
    check("t4_lane", a_lane, 1);
    send(4'h8, 1'b0);
    check("t4_err_pulse", a_err, 0);
    send(4'hA, 1'b0);
    idle();
    check("t4_frame", a_dout, 16'hA879);

    // 5: asynchronous reset between clock edges mid-frame
    send(4'h1, 1'b1); send(4'h2, 1'b0);
    @(posedge clk);
    #1 a_vld = 1'b0;
    check("t5_pre_lane", a_lane, 2);
    #1 rst_n = 1'b0;
    #1;
    check("t5_lane", a_lane, 0);
    check("t5_ovld", a_ovld, 0);
    check("t5_dout", a_dout, 0);
    check("t5_err", a_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    send(4'h4, 1'b1); send(4'h3, 1'b0); send(4'h2, 1'b0); send(4'h1, 1'b0);
    idle();
    check("t5_frame", a_dout, 16'h1234);

    // 6: three-lane instance wraps 2 -> 0
    bf = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b_vld = 1'b1; b_din = 2'(i * 3 + 1); b_fs = (i % 3 == 0);
      #2;
      check("t6_rdy", b_rdy, 1);
      check("t6_lane", b_lane, i % 3);
      bf[(i % 3)*2 +: 2] = b_din;
      if (i % 3 == 2) qb.push_back(bf);
    end
    @(negedge clk);
    b_vld = 1'b0; b_fs = 1'b0;

    repeat (5) @(negedge clk);
    #2;
    check("a_sb_drained", qa.size(), 0);
    check("b_sb_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
